// File: rtl/life_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : life_pkg
//  Description : Shared constants and types for the Game-of-Life engine.
//  Revision    : 1.0  initial release
// ============================================================================
package life_pkg;

  localparam int COLS_DEF = 32;
  localparam int ROWS_DEF = 24;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_CAPT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_CLR   = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  typedef logic [COLS_DEF-1:0] row_t;

endpackage
`default_nettype wire

// File: rtl/life_row_next.sv
`default_nettype none
// ============================================================================
//  Module      : life_row_next
//  Description : Combinational B3/S23 rule for one row, with column wrap.
//                Row wrap is handled by whoever supplies above/below.
//  Revision    : 1.0  initial release
// ============================================================================
module life_row_next #(
  parameter int COLS = 32
) (
  input  logic [COLS-1:0] i_above,
  input  logic [COLS-1:0] i_mid,
  input  logic [COLS-1:0] i_below,
  output logic [COLS-1:0] o_next
);

  for (genvar c = 0; c < COLS; c++) begin : g_col
    localparam int c_left  = (c == 0) ? COLS - 1 : c - 1;
    localparam int c_right = (c == COLS - 1) ? 0 : c + 1;

    // Eight neighbours sum to at most 8, so 4 bits never overflow.
    logic [3:0] w_cnt;
    assign w_cnt = 4'(i_above[c_left]) + 4'(i_above[c]) + 4'(i_above[c_right])
                 + 4'(i_mid[c_left])                    + 4'(i_mid[c_right])
                 + 4'(i_below[c_left]) + 4'(i_below[c]) + 4'(i_below[c_right]);

    assign o_next[c] = (w_cnt == 4'd3) | (i_mid[c] & (w_cnt == 4'd2));
  end

endmodule
`default_nettype wire

// File: rtl/life_gen_engine.sv
`default_nettype none
// ============================================================================
//  Module      : life_gen_engine
//  Description : Steps one Game-of-Life generation over a ping-pong row
//                memory using a three-row sliding window, or clears the
//                displayed bank. Keeps the generation counter.
//  Revision    : 1.0  initial release
// ============================================================================
module life_gen_engine
  import life_pkg::*;
#(
  parameter int COLS   = COLS_DEF,
  parameter int ROWS   = ROWS_DEF,
  parameter int ROW_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              clear,
  output logic              busy,
  output logic              done,
  output logic              disp_bank,
  output logic [15:0]       gen_count,
  output logic              rd_en,
  output logic [ROW_AW:0]   rd_addr,
  input  logic [COLS-1:0]   rd_data,
  output logic              wr_en,
  output logic [ROW_AW:0]   wr_addr,
  output logic [COLS-1:0]   wr_data
);

  localparam logic [ROW_AW-1:0] c_last_row = ROW_AW'(ROWS - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ROW_AW-1:0] r_row;
  logic [1:0]        r_pre;       // window rows captured so far (saturates at 3)
  logic              r_is_clr;    // DONE finishes a clear rather than a step
  logic              r_disp_bank;
  logic [15:0]       r_gen_count;
  logic [COLS-1:0]   r_above;
  logic [COLS-1:0]   r_mid;
  logic [COLS-1:0]   r_below;
  logic [COLS-1:0]   w_next_row;
  logic [ROW_AW:0]   w_rd_sum;
  logic [ROW_AW-1:0] w_rd_row;

  life_row_next #(.COLS(COLS)) u_row_next (
    .i_above (r_above),
    .i_mid   (r_mid),
    .i_below (r_below),
    .o_next  (w_next_row)
  );

  // Row two below the one being written, wrapped to the top of the board.
  assign w_rd_sum = {1'b0, r_row} + (ROW_AW+1)'(2);
  assign w_rd_row = (w_rd_sum >= (ROW_AW+1)'(ROWS)) ?
                    ROW_AW'(w_rd_sum - (ROW_AW+1)'(ROWS)) : w_rd_sum[ROW_AW-1:0];

  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_DONE);
  assign disp_bank = r_disp_bank;
  assign gen_count = r_gen_count;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state decode and memory strobes.
  always_comb begin
    w_state_nxt = r_state;
    rd_en       = 1'b0;
    rd_addr     = '0;
    wr_en       = 1'b0;
    wr_addr     = '0;
    wr_data     = '0;
    case (r_state)
      ST_IDLE: begin
        if (clear)      w_state_nxt = ST_CLR;
        else if (start) w_state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        rd_en       = 1'b1;
        rd_addr     = {r_disp_bank, r_row};
        w_state_nxt = ST_CAPT;
      end
      ST_CAPT: begin
        w_state_nxt = (r_pre >= 2'd2) ? ST_WRITE : ST_FETCH;
      end
      ST_WRITE: begin
        wr_en   = 1'b1;
        wr_addr = {~r_disp_bank, r_row};
        wr_data = w_next_row;
        if (r_row == c_last_row) begin
          w_state_nxt = ST_DONE;
        end else begin
          rd_en       = 1'b1;
          rd_addr     = {r_disp_bank, w_rd_row};
          w_state_nxt = ST_CAPT;
        end
      end
      ST_CLR: begin
        wr_en       = 1'b1;
        wr_addr     = {r_disp_bank, r_row};
        w_state_nxt = (r_row == c_last_row) ? ST_DONE : ST_CLR;
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Window shifting, row pointer, bank flip and generation counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_row       <= '0;
      r_pre       <= '0;
      r_is_clr    <= 1'b0;
      r_disp_bank <= 1'b0;
      r_gen_count <= '0;
      r_above     <= '0;
      r_mid       <= '0;
      r_below     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (clear) begin
            r_row    <= '0;
            r_is_clr <= 1'b1;
          end else if (start) begin
            r_row    <= c_last_row;
            r_pre    <= '0;
            r_is_clr <= 1'b0;
          end
        end
        ST_CAPT: begin
          r_below <= rd_data;
          // During preload every capture also shifts the window up.
          if (r_pre != 2'd3) begin
            r_above <= r_mid;
            r_mid   <= r_below;
            r_pre   <= r_pre + 2'd1;
            if (r_pre == 2'd2 || r_row == c_last_row) r_row <= '0;
            else                                      r_row <= r_row + ROW_AW'(1);
          end
        end
        ST_WRITE: begin
          r_above <= r_mid;
          r_mid   <= r_below;
          if (r_row != c_last_row) r_row <= r_row + ROW_AW'(1);
        end
        ST_CLR: begin
          if (r_row != c_last_row) r_row <= r_row + ROW_AW'(1);
        end
        ST_DONE: begin
          if (r_is_clr) begin
            r_gen_count <= '0;
          end else begin
            r_disp_bank <= ~r_disp_bank;
            r_gen_count <= r_gen_count + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_life_gen_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_life_gen_engine
//  Description : Self-checking bench for life_gen_engine with a behavioural
//                ping-pong memory and a cell-array reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_life_gen_engine;
  import life_pkg::*;

  localparam int COLS     = 32;
  localparam int ROWS     = 24;
  localparam int ROW_AW   = 5;
  localparam int BS       = 1 << ROW_AW;
  localparam int STEP_CYC = 6 + 2 * ROWS;

  logic              clk = 1'b0;
  logic              reset, start, clear;
  logic              busy, done, disp_bank;
  logic [15:0]       gen_count;
  logic              rd_en, wr_en;
  logic [ROW_AW:0]   rd_addr, wr_addr;
  logic [COLS-1:0]   rd_data, wr_data;

  life_gen_engine #(.COLS(COLS), .ROWS(ROWS), .ROW_AW(ROW_AW)) dut (
    .clk(clk), .reset(reset), .start(start), .clear(clear),
    .busy(busy), .done(done), .disp_bank(disp_bank), .gen_count(gen_count),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  row_t  mem     [2*BS];
  row_t  ld_img  [ROWS];
  row_t  pat_img [ROWS];
  row_t  exp_img [ROWS];
  row_t  ref_b   [ROWS];
  row_t  snap    [ROWS];
  logic  ld_go, ld_bank;
  int    rd_cnt = 0, wr_cnt = 0, clash_cnt = 0;
  int    n_vec = 0, n_bad = 0;
  logic  exp_disp;
  logic [15:0] exp_gen;

  // Behavioural row memory: one-cycle read latency plus a bulk loader.
  always @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
      rd_cnt  <= rd_cnt + 1;
    end
    if (ld_go) begin
      for (int r = 0; r < ROWS; r++) mem[int'(ld_bank) * BS + r] <= ld_img[r];
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
      wr_cnt       <= wr_cnt + 1;
    end
    if (rd_en && wr_en && (rd_addr[ROW_AW] == wr_addr[ROW_AW])) clash_cnt <= clash_cnt + 1;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, want);
    end
  endtask

  // Reference: plain neighbour counting over a toroidal cell array.
  task automatic ref_step();
    row_t nx [ROWS];
    for (int r = 0; r < ROWS; r++) begin
      nx[r] = '0;
      for (int c = 0; c < COLS; c++) begin
        int n;
        n = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if (dr != 0 || dc != 0)
              n += int'(ref_b[(r + dr + ROWS) % ROWS][(c + dc + COLS) % COLS]);
        nx[r][c] = (n == 3) || (ref_b[r][c] && n == 2);
      end
    end
    for (int r = 0; r < ROWS; r++) ref_b[r] = nx[r];
  endtask

  task automatic check_bank(input logic bank, input bit use_exp, input string nm);
    int   bad_row;
    row_t got, want;
    bad_row = -1;
    got = '0;
    want = '0;
    for (int r = 0; r < ROWS; r++) begin
      row_t w;
      w = use_exp ? exp_img[r] : ref_b[r];
      if (bad_row < 0 && mem[int'(bank) * BS + r] !== w) begin
        bad_row = r;
        got  = mem[int'(bank) * BS + r];
        want = w;
      end
    end
    n_vec++;
    if (bad_row >= 0) begin
      n_bad++;
      $display("FAIL %s: row %0d got 0x%h, expected 0x%h", nm, bad_row, got, want);
    end
  endtask

  task automatic load_bank(input logic bank);
    @(negedge clk);
    ld_bank = bank;
    ld_go   = 1'b1;
    @(negedge clk);
    ld_go   = 1'b0;
  endtask

  // Garbage into the write bank, pat_img into the displayed bank.
  task automatic load_state();
    for (int r = 0; r < ROWS; r++) ld_img[r] = $urandom;
    load_bank(~exp_disp);
    for (int r = 0; r < ROWS; r++) begin
      ld_img[r] = pat_img[r];
      ref_b[r]  = pat_img[r];
    end
    load_bank(exp_disp);
  endtask

  task automatic do_step(input bit noise);
    int cyc;
    bit seen, allb;
    cyc = 0; seen = 0; allb = 1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 1; k <= 4 * ROWS + 40; k++) begin
      if (!busy) allb = 0;
      if (done) begin seen = 1; cyc = k; break; end
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      clear = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
    end
    start = 1'b0; clear = 1'b0;
    exp_disp = ~exp_disp;
    exp_gen  = exp_gen + 16'd1;
    chk("step_done_seen", 64'(seen), 64'd1);
    chk("step_latency", 64'(cyc), 64'(STEP_CYC));
    chk("step_busy_held", 64'(allb), 64'd1);
    @(negedge clk);
    chk("step_idle", 64'(busy), 64'd0);
    chk("step_disp_bank", 64'(disp_bank), 64'(exp_disp));
    chk("step_gen_count", 64'(gen_count), 64'(exp_gen));
    ref_step();
    check_bank(exp_disp, 1'b0, "step_board_model");
  endtask

  task automatic do_clear(input bit with_start);
    int cyc;
    cyc = 0;
    @(negedge clk); clear = 1'b1; start = with_start;
    @(negedge clk); clear = 1'b0; start = 1'b0;
    for (int k = 1; k <= ROWS + 20; k++) begin
      if (done) begin cyc = k; break; end
      @(negedge clk);
    end
    exp_gen = 16'd0;
    for (int r = 0; r < ROWS; r++) ref_b[r] = '0;
    chk("clr_latency", 64'(cyc), 64'(ROWS + 1));
    @(negedge clk);
    chk("clr_idle", 64'(busy), 64'd0);
    chk("clr_gen_count", 64'(gen_count), 64'd0);
    chk("clr_disp_bank", 64'(disp_bank), 64'(exp_disp));
    check_bank(exp_disp, 1'b0, "clr_board");
  endtask

  typedef struct {
    string      name;
    int         base;
    logic [31:0] in0, in1, in2;
    logic [31:0] ex0, ex1, ex2;
  } vec_t;

  vec_t vt [6];

  initial begin
    int rd0, wr0;
    vt[0] = '{"blinker_vert",  4, 32'h10, 32'h10, 32'h10, 32'h0, 32'h38, 32'h0};
    vt[1] = '{"blinker_horiz", 4, 32'h0, 32'h38, 32'h0, 32'h10, 32'h10, 32'h10};
    vt[2] = '{"block",         0, 32'h3, 32'h3, 32'h0, 32'h3, 32'h3, 32'h0};
    vt[3] = '{"lonely_cell",  10, 32'h0, 32'h100, 32'h0, 32'h0, 32'h0, 32'h0};
    vt[4] = '{"col_wrap",      4, 32'h0, 32'h80000003, 32'h0, 32'h1, 32'h1, 32'h1};
    vt[5] = '{"row_wrap",     23, 32'h10, 32'h10, 32'h10, 32'h0, 32'h38, 32'h0};

    reset = 1'b1; start = 1'b0; clear = 1'b0; ld_go = 1'b0; ld_bank = 1'b0;
    exp_disp = 1'b0; exp_gen = 16'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_disp_bank", 64'(disp_bank), 64'd0);
    chk("rst_gen_count", 64'(gen_count), 64'd0);
    chk("rst_rd_en", 64'(rd_en), 64'd0);
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_rd_addr", 64'(rd_addr), 64'd0);
    chk("rst_wr_addr", 64'(wr_addr), 64'd0);
    chk("rst_wr_data", 64'(wr_data), 64'd0);
    reset = 1'b0;

    // Table-driven single-step patterns.
    for (int i = 0; i < 6; i++) begin
      for (int r = 0; r < ROWS; r++) begin pat_img[r] = '0; exp_img[r] = '0; end
      pat_img[vt[i].base % ROWS]       = vt[i].in0;
      pat_img[(vt[i].base + 1) % ROWS] = vt[i].in1;
      pat_img[(vt[i].base + 2) % ROWS] = vt[i].in2;
      exp_img[vt[i].base % ROWS]       = vt[i].ex0;
      exp_img[(vt[i].base + 1) % ROWS] = vt[i].ex1;
      exp_img[(vt[i].base + 2) % ROWS] = vt[i].ex2;
      load_state();
      do_step(1'b0);
      check_bank(exp_disp, 1'b1, vt[i].name);
    end

    // Blinker returns to its original phase after two steps.
    for (int r = 0; r < ROWS; r++) pat_img[r] = '0;
    pat_img[4] = 32'h10; pat_img[5] = 32'h10; pat_img[6] = 32'h10;
    load_state();
    do_step(1'b0);
    do_step(1'b0);
    for (int r = 0; r < ROWS; r++) exp_img[r] = pat_img[r];
    check_bank(exp_disp, 1'b1, "blinker_restore");

    // Glider straddling both wrap seams moves one cell down-right in 4 steps.
    do_clear(1'b0);
    for (int r = 0; r < ROWS; r++) begin pat_img[r] = '0; exp_img[r] = '0; end
    pat_img[ROWS-1] = 32'h1; pat_img[0] = 32'h2; pat_img[1] = 32'h80000003;
    exp_img[0] = 32'h2; exp_img[1] = 32'h4; exp_img[2] = 32'h7;
    load_state();
    repeat (4) do_step(1'b0);
    check_bank(exp_disp, 1'b1, "glider_shift");
    chk("glider_gen_count", 64'(gen_count), 64'd4);

    // Random boards against the reference model.
    for (int b = 0; b < 4; b++) begin
      for (int r = 0; r < ROWS; r++) pat_img[r] = $urandom & $urandom;
      load_state();
      repeat (1 + $urandom_range(0, 2)) do_step(1'b0);
    end

    // Clear wins over start; zeroes only the displayed bank.
    do_clear(1'b0);
    for (int r = 0; r < ROWS; r++) pat_img[r] = $urandom;
    load_state();
    repeat (7) do_step(1'b0);
    chk("pre_clr_gen_count", 64'(gen_count), 64'd7);
    for (int r = 0; r < ROWS; r++) ld_img[r] = $urandom | 32'h1;
    load_bank(exp_disp);
    for (int r = 0; r < ROWS; r++) snap[r] = mem[int'(~exp_disp) * BS + r];
    rd0 = rd_cnt; wr0 = wr_cnt;
    do_clear(1'b1);
    chk("clr_no_reads", 64'(rd_cnt - rd0), 64'd0);
    chk("clr_write_count", 64'(wr_cnt - wr0), 64'(ROWS));
    for (int r = 0; r < ROWS; r++) exp_img[r] = snap[r];
    check_bank(~exp_disp, 1'b1, "clr_other_bank_kept");

    // Requests while busy are ignored.
    for (int r = 0; r < ROWS; r++) pat_img[r] = $urandom & $urandom;
    load_state();
    rd0 = rd_cnt; wr0 = wr_cnt;
    do_step(1'b1);
    chk("noise_write_count", 64'(wr_cnt - wr0), 64'(ROWS));
    chk("noise_read_count", 64'(rd_cnt - rd0), 64'(ROWS + 2));

    // Reset in the middle of a step.
    if (exp_disp == 1'b0) do_step(1'b0);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (19) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_disp_bank", 64'(disp_bank), 64'd0);
    chk("midrst_gen_count", 64'(gen_count), 64'd0);
    chk("midrst_wr_en", 64'(wr_en), 64'd0);
    reset = 1'b0;
    exp_disp = 1'b0; exp_gen = 16'd0;
    for (int r = 0; r < ROWS; r++) pat_img[r] = $urandom & $urandom;
    load_state();
    do_step(1'b0);

    chk("bank_clash", 64'(clash_cnt), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
